// File: rtl/miner_pkg.sv
// Shared types and defaults for the nonce dispatcher and its helpers.
package miner_pkg;

  localparam int unsigned NONCE_W_DEF   = 32;
  localparam int unsigned NUM_CORES_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPATCH = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_REPORT   = 2'd3
  } dispatch_state_t;

endpackage

// File: rtl/miner_nonce_dispatch_if.sv
// Job front-end and hash-core bus seen by the nonce dispatcher.
interface miner_nonce_dispatch_if
  import miner_pkg::*;
#(
  parameter int unsigned NUM_CORES = NUM_CORES_DEF,
  parameter int unsigned NONCE_W   = NONCE_W_DEF
);

  logic                 job_valid;
  logic                 job_ready;
  logic [NONCE_W-1:0]   nonce_start;
  logic [NONCE_W-1:0]   nonce_end;
  logic                 abort;
  logic [NUM_CORES-1:0] core_start;
  logic [NONCE_W-1:0]   core_nonce;
  logic [NUM_CORES-1:0] core_finished;
  logic [NUM_CORES-1:0] core_hit;
  logic                 busy;
  logic                 done;
  logic                 found;
  logic [NONCE_W-1:0]   found_nonce;

  // Environment side: job loader plus the hash-core array.
  modport master (
    output job_valid, nonce_start, nonce_end, abort, core_finished, core_hit,
    input  job_ready, core_start, core_nonce, busy, done, found, found_nonce
  );

  // Dispatcher side.
  modport slave (
    input  job_valid, nonce_start, nonce_end, abort, core_finished, core_hit,
    output job_ready, core_start, core_nonce, busy, done, found, found_nonce
  );

endinterface

// File: rtl/miner_rr_pick.sv
// Combinational round-robin picker: first idle requester at or after ptr_i, wrapping.
module miner_rr_pick #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         idle_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic                 grant_valid_c_o,
  output logic [N-1:0]         grant_c_o
);

  localparam int unsigned PTR_W = $clog2(N);

  // Scan N positions starting at the pointer; the first idle one wins.
  always_comb begin
    int unsigned idx;
    logic        hit;
    grant_c_o       = '0;
    grant_valid_c_o = 1'b0;
    hit             = 1'b0;
    idx             = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(ptr_i) + k) % N;
      if (!hit && idle_i[PTR_W'(idx)]) begin
        hit                      = 1'b1;
        grant_c_o[PTR_W'(idx)]   = 1'b1;
      end
    end
    grant_valid_c_o = hit;
  end

endmodule

// File: rtl/miner_nonce_dispatch.sv
// Hands nonces of one job to a pool of hash cores and reports the first hit or exhaustion.
module miner_nonce_dispatch
  import miner_pkg::*;
#(
  parameter int unsigned NUM_CORES = NUM_CORES_DEF,
  parameter int unsigned NONCE_W   = NONCE_W_DEF
) (
  input  logic                   clk,
  input  logic                   n_rst,
  miner_nonce_dispatch_if.slave  bus
);

  localparam int unsigned PTR_W = $clog2(NUM_CORES);

  dispatch_state_t      state_q, state_d;
  logic [NONCE_W-1:0]   next_nonce_q, next_nonce_d;
  logic [NONCE_W-1:0]   last_nonce_q, last_nonce_d;
  logic [NUM_CORES-1:0] active_q, active_d;
  logic                 hit_seen_q, hit_seen_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NONCE_W-1:0]   rec_nonce_q, rec_nonce_d;
  logic [NONCE_W-1:0]   issued_q [NUM_CORES];
  logic [NONCE_W-1:0]   issued_d [NUM_CORES];
  logic [NUM_CORES-1:0] core_start_q, core_start_d;
  logic [NONCE_W-1:0]   core_nonce_q, core_nonce_d;
  logic                 done_q, done_d;
  logic                 found_q, found_d;
  logic [NONCE_W-1:0]   found_nonce_q, found_nonce_d;

  logic [NUM_CORES-1:0] fin_live_c;
  logic [NUM_CORES-1:0] hit_live_c;
  logic                 hit_any_c;
  logic [PTR_W-1:0]     hit_idx_c;
  logic                 grant_valid_c;
  logic [NUM_CORES-1:0] grant_c;
  logic [PTR_W-1:0]     grant_idx_c;

  // Finishes on cores without an outstanding nonce are dropped here.
  assign fin_live_c = bus.core_finished & active_q;
  assign hit_live_c = fin_live_c & bus.core_hit;

  miner_rr_pick #(.N(NUM_CORES)) u_pick (
    .idle_i          (~active_q),
    .ptr_i           (rr_ptr_q),
    .grant_valid_c_o (grant_valid_c),
    .grant_c_o       (grant_c)
  );

  // Lowest-index hit and the index of the one-hot grant.
  always_comb begin
    hit_any_c   = 1'b0;
    hit_idx_c   = '0;
    grant_idx_c = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (!hit_any_c && hit_live_c[i]) begin
        hit_any_c = 1'b1;
        hit_idx_c = PTR_W'(i);
      end
      if (grant_c[i]) begin
        grant_idx_c = PTR_W'(i);
      end
    end
  end

  // Next-state and registered-output decode.
  always_comb begin
    state_d       = state_q;
    next_nonce_d  = next_nonce_q;
    last_nonce_d  = last_nonce_q;
    active_d      = active_q & ~fin_live_c;
    hit_seen_d    = hit_seen_q;
    rr_ptr_d      = rr_ptr_q;
    rec_nonce_d   = rec_nonce_q;
    issued_d      = issued_q;
    core_start_d  = '0;
    core_nonce_d  = '0;
    done_d        = 1'b0;
    found_d       = 1'b0;
    found_nonce_d = '0;

    if ((state_q == ST_DISPATCH || state_q == ST_DRAIN) && hit_any_c && !hit_seen_q) begin
      hit_seen_d  = 1'b1;
      rec_nonce_d = issued_q[hit_idx_c];
    end

    case (state_q)
      ST_IDLE: begin
        // The first nonce goes straight to core 0 so it appears the cycle after acceptance.
        if (bus.job_valid) begin
          hit_seen_d   = 1'b0;
          rec_nonce_d  = '0;
          last_nonce_d = bus.nonce_end;
          next_nonce_d = bus.nonce_start + NONCE_W'(1);
          active_d     = NUM_CORES'(1);
          rr_ptr_d     = PTR_W'(1);
          issued_d[0]  = bus.nonce_start;
          core_start_d = NUM_CORES'(1);
          core_nonce_d = bus.nonce_start;
          state_d      = (bus.nonce_start == bus.nonce_end) ? ST_DRAIN : ST_DISPATCH;
        end
      end
      ST_DISPATCH: begin
        if (bus.abort || (hit_any_c && !hit_seen_q)) begin
          state_d = ST_DRAIN;
        end else if (grant_valid_c) begin
          core_start_d           = grant_c;
          core_nonce_d           = next_nonce_q;
          active_d               = active_d | grant_c;
          issued_d[grant_idx_c]  = next_nonce_q;
          rr_ptr_d               = (grant_idx_c == PTR_W'(NUM_CORES - 1)) ? '0
                                                                          : grant_idx_c + PTR_W'(1);
          next_nonce_d           = next_nonce_q + NONCE_W'(1);
          if (next_nonce_q == last_nonce_q) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (active_d == '0) begin
          state_d       = ST_REPORT;
          done_d        = 1'b1;
          found_d       = hit_seen_d;
          found_nonce_d = hit_seen_d ? rec_nonce_d : '0;
        end
      end
      ST_REPORT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= ST_IDLE;
      next_nonce_q  <= '0;
      last_nonce_q  <= '0;
      active_q      <= '0;
      hit_seen_q    <= 1'b0;
      rr_ptr_q      <= '0;
      rec_nonce_q   <= '0;
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
        issued_q[i] <= '0;
      end
      core_start_q  <= '0;
      core_nonce_q  <= '0;
      done_q        <= 1'b0;
      found_q       <= 1'b0;
      found_nonce_q <= '0;
    end else begin
      state_q       <= state_d;
      next_nonce_q  <= next_nonce_d;
      last_nonce_q  <= last_nonce_d;
      active_q      <= active_d;
      hit_seen_q    <= hit_seen_d;
      rr_ptr_q      <= rr_ptr_d;
      rec_nonce_q   <= rec_nonce_d;
      issued_q      <= issued_d;
      core_start_q  <= core_start_d;
      core_nonce_q  <= core_nonce_d;
      done_q        <= done_d;
      found_q       <= found_d;
      found_nonce_q <= found_nonce_d;
    end
  end

  assign bus.job_ready   = (state_q == ST_IDLE);
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.core_start  = core_start_q;
  assign bus.core_nonce  = core_nonce_q;
  assign bus.done        = done_q;
  assign bus.found       = found_q;
  assign bus.found_nonce = found_nonce_q;

endmodule

// File: tb/tb_miner_nonce_dispatch.sv
// Bench for miner_nonce_dispatch: emulated hash cores plus a job-level reference model.
module tb_miner_nonce_dispatch;

  localparam int NC = 4;
  localparam int P_IDLE = 0, P_ISSUE = 1, P_DRAIN = 2, P_REPORT = 3;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  miner_nonce_dispatch_if #(.NUM_CORES(NC), .NONCE_W(32)) bus ();

  miner_nonce_dispatch #(.NUM_CORES(NC), .NONCE_W(32)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model of the job
  int          m_phase;
  bit [NC-1:0] m_out;
  logic [31:0] m_nonce_of [NC];
  int          m_rr;
  logic [31:0] m_next;
  longint      m_left;
  bit          m_hit;
  logic [31:0] m_fn;

  // Emulated cores
  int          fin_at [NC];
  bit          fin_hit [NC];
  logic [31:0] hit_set [$];
  logic [31:0] lat_nonce [$];
  int          lat_val [$];
  int          lat_lo, lat_hi;
  logic [NC-1:0] spur_fin, spur_hit;

  // Observed job summary
  int          starts_cnt;
  logic [31:0] last_fn;
  logic        last_found;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic bit is_hit(input logic [31:0] n);
    foreach (hit_set[k]) if (hit_set[k] == n) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int pick_lat(input logic [31:0] n);
    foreach (lat_nonce[k]) if (lat_nonce[k] == n) return lat_val[k];
    return int'($urandom_range(lat_hi, lat_lo));
  endfunction

  function automatic int first_free();
    for (int k = 0; k < NC; k++) begin
      int idx;
      idx = (m_rr + k) % NC;
      if (!m_out[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE; m_out = '0; m_rr = 0; m_next = '0; m_left = 0;
    m_hit = 1'b0; m_fn = '0;
    for (int i = 0; i < NC; i++) begin
      fin_at[i] = -1; fin_hit[i] = 1'b0; m_nonce_of[i] = '0;
    end
    spur_fin = '0; spur_hit = '0;
  endtask

  // One clock: drive inputs, advance, then compare the DUT with the model's expectation.
  task automatic step(input bit jv, input bit ab, input logic [31:0] s, input logic [31:0] e);
    logic [NC-1:0] fin, hv, exp_start;
    logic [31:0]   exp_nonce, diff;
    bit            hit_now, exp_done;
    int            pick, pre;
    fin = spur_fin;
    hv  = spur_hit;
    for (int i = 0; i < NC; i++) begin
      if (fin_at[i] == cyc) begin
        fin[i] = 1'b1; hv[i] = fin_hit[i]; fin_at[i] = -1;
      end
    end
    bus.job_valid = jv; bus.abort = ab;
    bus.nonce_start = s; bus.nonce_end = e;
    bus.core_finished = fin; bus.core_hit = hv;
    @(posedge clk); #1;
    cyc++;
    spur_fin = '0; spur_hit = '0;

    pre = m_phase;
    hit_now = 1'b0;
    if ((pre == P_ISSUE || pre == P_DRAIN) && !m_hit) begin
      for (int i = 0; i < NC; i++) begin
        if (!hit_now && fin[i] && m_out[i] && hv[i]) begin
          hit_now = 1'b1; m_hit = 1'b1; m_fn = m_nonce_of[i];
        end
      end
    end
    pick = -1;
    if (pre == P_IDLE && jv) begin
      diff = e - s;
      m_left = longint'(diff) + 1;
      m_next = s; m_hit = 1'b0; m_fn = '0; m_rr = 0;
      pick = first_free();
      m_phase = P_ISSUE;
    end else if (pre == P_ISSUE) begin
      if (ab || hit_now) m_phase = P_DRAIN;
      else pick = first_free();
    end else if (pre == P_REPORT) begin
      m_phase = P_IDLE;
    end
    m_out = m_out & ~fin;
    exp_start = '0; exp_nonce = '0; exp_done = 1'b0;
    if (pick >= 0) begin
      exp_start[pick] = 1'b1; exp_nonce = m_next;
      m_out[pick] = 1'b1; m_nonce_of[pick] = m_next; m_rr = (pick + 1) % NC;
      fin_at[pick] = cyc + pick_lat(m_next); fin_hit[pick] = is_hit(m_next);
      m_next = m_next + 32'd1; m_left--;
      if (m_left == 0) m_phase = P_DRAIN;
    end
    if (pre == P_DRAIN && m_out == '0) begin
      m_phase = P_REPORT; exp_done = 1'b1;
    end

    starts_cnt += $countones(bus.core_start);
    if (bus.done === 1'b1) begin
      last_fn = bus.found_nonce; last_found = bus.found;
    end
    chk("core_start", 64'(bus.core_start), 64'(exp_start));
    if (exp_start != '0) chk("core_nonce", 64'(bus.core_nonce), 64'(exp_nonce));
    chk("done", 64'(bus.done), 64'(exp_done));
    if (exp_done) begin
      chk("found", 64'(bus.found), 64'(m_hit));
      chk("found_nonce", 64'(bus.found_nonce), m_hit ? 64'(m_fn) : 64'd0);
    end
    chk("job_ready", 64'(bus.job_ready), 64'(m_phase == P_IDLE));
    chk("busy", 64'(bus.busy), 64'(m_phase != P_IDLE));
  endtask

  task automatic run_job(input logic [31:0] s, input logic [31:0] e, input int abort_at,
                         input int spur_at, input bit hold);
    int n;
    n = 0;
    starts_cnt = 0; last_fn = 'x; last_found = 'x;
    step(1'b1, 1'b0, s, e);
    while (m_phase != P_IDLE && n < 3000) begin
      n++;
      if (n == spur_at) begin
        spur_fin = 4'b1000; spur_hit = 4'b1000;
      end
      step(hold, n == abort_at, s, e);
    end
    chk("job_ready_after_job", 64'(bus.job_ready), 64'd1);
  endtask

  task automatic set_job(input int lo, input int hi);
    lat_lo = lo; lat_hi = hi;
    hit_set.delete(); lat_nonce.delete(); lat_val.delete();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_job_ready"}, 64'(bus.job_ready), 64'd1);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
    chk({tag, "_core_start"}, 64'(bus.core_start), 64'd0);
    chk({tag, "_core_nonce"}, 64'(bus.core_nonce), 64'd0);
    chk({tag, "_done"}, 64'(bus.done), 64'd0);
    chk({tag, "_found"}, 64'(bus.found), 64'd0);
    chk({tag, "_found_nonce"}, 64'(bus.found_nonce), 64'd0);
  endtask

  initial begin
    logic [31:0] s, e;
    int len, ab_at;
    bus.job_valid = 1'b0; bus.abort = 1'b0;
    bus.nonce_start = '0; bus.nonce_end = '0;
    bus.core_finished = '0; bus.core_hit = '0;
    model_reset();
    starts_cnt = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk); n_rst = 1'b1;

    // Plain range, fixed 50-cycle cores, no hits
    set_job(50, 50);
    run_job(32'h10, 32'h15, -1, -1, 1'b0);
    chk("t1_starts", 64'(starts_cnt), 64'd6);
    chk("t1_found", 64'(last_found), 64'd0);

    // Hit on 0x102 from core 2
    set_job(30, 30);
    hit_set.push_back(32'h102);
    run_job(32'h100, 32'h1FF, -1, -1, 1'b0);
    chk("t2_found", 64'(last_found), 64'd1);
    chk("t2_found_nonce", 64'(last_fn), 64'h102);

    // Wrapping range
    set_job(3, 9);
    run_job(32'hFFFF_FFFE, 32'h0000_0001, -1, -1, 1'b0);
    chk("t3_starts", 64'(starts_cnt), 64'd4);

    // Simultaneous hits on cores 1 and 3
    set_job(10, 10);
    hit_set.push_back(32'h21); hit_set.push_back(32'h23);
    lat_nonce.push_back(32'h23); lat_val.push_back(8);
    run_job(32'h20, 32'h2F, -1, -1, 1'b0);
    chk("t4_found_nonce", 64'(last_fn), 64'h21);

    // Abort two cycles after acceptance, with a spurious finish+hit on idle core 3
    set_job(20, 20);
    hit_set.push_back(32'h303);
    run_job(32'h300, 32'h3FF, 2, 5, 1'b0);
    chk("t5_starts", 64'(starts_cnt), 64'd2);
    chk("t5_found", 64'(last_found), 64'd0);

    // Single-nonce range, with job_valid held through the whole job
    set_job(4, 4);
    run_job(32'h77, 32'h77, -1, -1, 1'b1);
    chk("t6_starts", 64'(starts_cnt), 64'd1);

    // Randomized jobs
    for (int j = 0; j < 12; j++) begin
      set_job(1, 10);
      s = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(15)) : $urandom;
      len = int'($urandom_range(16, 1));
      e = s + 32'(len - 1);
      if ($urandom_range(1) == 1) hit_set.push_back(s + 32'($urandom_range(len - 1)));
      ab_at = ($urandom_range(3) == 0) ? int'($urandom_range(8, 1)) : -1;
      run_job(s, e, ab_at, -1, 1'($urandom_range(1)));
    end

    // Reset pulsed in the middle of dispatch
    set_job(6, 6);
    starts_cnt = 0;
    step(1'b1, 1'b0, 32'h500, 32'h5FF);
    for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 32'h500, 32'h5FF);
    bus.job_valid = 1'b0; bus.core_finished = '0; bus.core_hit = '0;
    #2 n_rst = 1'b0;
    #1;
    check_reset_values("midreset");
    model_reset();
    @(negedge clk); n_rst = 1'b1;
    set_job(2, 7);
    hit_set.push_back(32'h603);
    run_job(32'h600, 32'h60F, -1, -1, 1'b0);
    chk("t8_found_nonce", 64'(last_fn), 64'h603);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
